input_checker: RTL and testbench
================================

INPUT_CHECKER -- requirements
Module: input_checker

Interface
REQ-001 The block SHALL have parameter SEQ_LEN, default 5, giving the number of entries in the player sequence, legal range 1..7.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable synchronized samples needed to accept a button value, legal range 1..255.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the per-press timeout in clocks; it is used only under INPUT_TIMEOUT_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all flops on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port current_state, input, 2 bits: game state, where 2'b10 is INPUT and every other value is non-INPUT.
REQ-007 The block SHALL have port CorrectMemory, input, array of SEQ_LEN x 2 bits: expected button code for each position, to be held stable during INPUT.
REQ-008 The block SHALL have port buttons, input, 4 bits: raw asynchronous active-high push buttons, where bit k corresponds to code k.
REQ-009 The block SHALL have port input_index, output, 3 bits: count of correct presses accepted in the current round.
REQ-010 The block SHALL have port input_done, output, 1 bit: one-cycle pulse when the whole sequence has been entered correctly.
REQ-011 The block SHALL have port input_error, output, 1 bit: one-cycle pulse on a wrong, multi-button or timed-out press.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the FSM is in WAIT_PRESS or WAIT_RELEASE.

Function
REQ-013 buttons SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debouncer SHALL accept a new value only after the synchronized value has been identical for DEBOUNCE_CYCLES consecutive cycles; any change SHALL restart the count.
REQ-015 The FSM SHALL have exactly the states IDLE, WAIT_PRESS, WAIT_RELEASE, PASS and FAIL.
REQ-016 In IDLE, the FSM SHALL move to WAIT_PRESS and set input_index to 0 on the first cycle current_state==2'b10.
REQ-017 In WAIT_PRESS, a debounced value of 4'b0000 SHALL be ignored.
REQ-018 In WAIT_PRESS, a debounced one-hot value SHALL be encoded to a 2-bit code and compared with CorrectMemory[input_index] on that same cycle.
REQ-019 On a match with input_index<SEQ_LEN-1, the block SHALL increment input_index on the next edge and go to WAIT_RELEASE.
REQ-020 On a match with input_index==SEQ_LEN-1, the block SHALL set input_index to SEQ_LEN, pulse input_done for one cycle and go to PASS.
REQ-021 On a mismatch, or on a debounced value with more than one bit set, the block SHALL pulse input_error for one cycle, leave input_index unchanged and go to FAIL.
REQ-022 In WAIT_RELEASE, the FSM SHALL return to WAIT_PRESS only after the debounced value is 4'b0000; a held button SHALL never count twice.
REQ-023 PASS and FAIL SHALL hold input_index and keep both pulse outputs low.
REQ-024 From any state other than IDLE, current_state!=2'b10 SHALL force IDLE on the next edge, with no pulse, input_index held.
REQ-025 In that abort case, input_index SHALL be held until the next IDLE->WAIT_PRESS entry clears it.
REQ-026 If abort and an accepted press occur on the same cycle, abort SHALL win and no pulse or index change SHALL occur.
REQ-027 A press held while entering INPUT SHALL require release before it can count; on entry the FSM SHALL go through WAIT_RELEASE if the debounced value is nonzero.
REQ-028 input_done and input_error SHALL never be high on the same cycle.

Reset
REQ-029 While reset is low, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-030 While reset is low, the synchronizer, debounce value and counter, and timeout counter SHALL all be 0.
REQ-031 Assertion of reset mid-round SHALL abort immediately with no pulse; after deassertion the block SHALL be usable after 2 + DEBOUNCE_CYCLES clocks.

Configuration
REQ-032 With macro INPUT_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_PRESS and count in WAIT_PRESS.
REQ-033 With INPUT_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse input_error and go to FAIL; a press accepted on the same cycle SHALL take priority.
REQ-034 Without INPUT_TIMEOUT_EN, the timeout counter SHALL not exist and WAIT_PRESS SHALL wait indefinitely.

Verification
REQ-035 The bench SHALL cover: CorrectMemory={0,1,2,3,0}, INPUT, presses 0001,0010,0100,1000,0001 each held 10 cycles with releases -> input_index steps 1..5, one input_done pulse on press 5, state PASS.
REQ-036 The bench SHALL cover: same memory, press 0010 first -> input_error pulse, input_index=0, FAIL, no input_done.
REQ-037 The bench SHALL cover: button 0001 held 50 cycles after the first accepted press -> input_index stays 1 until release and re-press.
REQ-038 The bench SHALL cover: 3-cycle glitches on buttons with DEBOUNCE_CYCLES=4 -> no index change, no pulse.
REQ-039 The bench SHALL cover: current_state->2'b00 after 2 correct presses, then back to 2'b10 -> IDLE with index 2 held, then index 0 and WAIT_PRESS, no pulses.
REQ-040 The bench SHALL cover, with INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=20: no press for 20 cycles in WAIT_PRESS -> input_error pulse, FAIL; without the macro -> still WAIT_PRESS after 1000 cycles.

Source files
------------

// File: rtl/input_checker.sv
// Player input checker: synchronizes and debounces four push buttons, then
// walks the player's presses against CorrectMemory while the game is in INPUT.
// Optional feature macro: INPUT_TIMEOUT_EN (per-press timeout in WAIT_PRESS).
module input_checker #(
  parameter int unsigned SEQ_LEN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              current_state,
  input  logic [SEQ_LEN-1:0][1:0] CorrectMemory,
  input  logic [3:0]              buttons,
  output logic [2:0]              input_index,
  output logic                    input_done,
  output logic                    input_error,
  output logic                    busy
);

  localparam logic [1:0] GameInput = 2'b10;
  localparam logic [7:0] DbMax     = 8'(DEBOUNCE_CYCLES);
  localparam logic [2:0] LastIdx   = 3'(SEQ_LEN - 1);
  localparam logic [2:0] FullIdx   = 3'(SEQ_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPress,
    StWaitRelease,
    StPass,
    StFail
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] cand_q;
  logic [7:0] cnt_q;
  logic [3:0] db_q;
  logic [2:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] press_code;
  logic       db_onehot;
  logic       in_input;

`ifdef INPUT_TIMEOUT_EN
  localparam logic [31:0] TmrLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmr_q, tmr_d;
`endif

  assign in_input = (current_state == GameInput);

  // Two-flop synchronizer for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: cnt_q counts consecutive samples equal to cand_q; any change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q <= 4'b0000;
      cnt_q  <= 8'd0;
      db_q   <= 4'b0000;
    end else begin
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= 8'd1;
      end else if (cnt_q != DbMax) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (cnt_q == DbMax) begin
        db_q <= cand_q;
      end
    end
  end

  // One-hot to code encoder; anything not exactly one bit is flagged.
  always_comb begin
    press_code = 2'd0;
    db_onehot  = 1'b1;
    case (db_q)
      4'b0001: press_code = 2'd0;
      4'b0010: press_code = 2'd1;
      4'b0100: press_code = 2'd2;
      4'b1000: press_code = 2'd3;
      default: db_onehot  = 1'b0;
    endcase
  end

  // FSM state, index, pulse and timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      tmr_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef INPUT_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  // Next-state logic; leaving INPUT always wins over any press or timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef INPUT_TIMEOUT_EN
    tmr_d   = tmr_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_input) begin
          idx_d = 3'd0;
          // A button already held on entry must be released before it counts.
          if (db_q != 4'b0000) begin
            state_d = StWaitRelease;
          end else begin
            state_d = StWaitPress;
`ifdef INPUT_TIMEOUT_EN
            tmr_d   = 32'd0;
`endif
          end
        end
      end
      StWaitPress: begin
        if (!in_input) begin
          state_d = StIdle;
        end else if (db_q != 4'b0000) begin
          if (db_onehot && (press_code == CorrectMemory[idx_q])) begin
            if (idx_q == LastIdx) begin
              idx_d   = FullIdx;
              done_d  = 1'b1;
              state_d = StPass;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = StWaitRelease;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StFail;
          end
        end
`ifdef INPUT_TIMEOUT_EN
        else if (tmr_q == TmrLast) begin
          err_d   = 1'b1;
          state_d = StFail;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
`endif
      end
      StWaitRelease: begin
        if (!in_input) begin
          state_d = StIdle;
        end else if (db_q == 4'b0000) begin
          state_d = StWaitPress;
`ifdef INPUT_TIMEOUT_EN
          tmr_d   = 32'd0;
`endif
        end
      end
      StPass, StFail: begin
        if (!in_input) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign input_index = idx_q;
  assign input_done  = done_q;
  assign input_error = err_q;
  assign busy        = (state_q == StWaitPress) || (state_q == StWaitRelease);

endmodule

// File: tb/tb_input_checker.sv
// Directed self-checking bench for input_checker (honours INPUT_TIMEOUT_EN).
module tb_input_checker;

`ifdef INPUT_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 20;
`else
  localparam int unsigned TimeoutCycles = 1000;
`endif

  logic           clk;
  logic           reset;
  logic [1:0]     current_state;
  logic [4:0][1:0] mem;
  logic [3:0]     buttons;
  logic [2:0]     input_index;
  logic           input_done;
  logic           input_error;
  logic           busy;

  int tests_run;
  int tests_failed;
  int done_cnt;
  int err_cnt;
  int both_cnt;
  int d0;
  int e0;

  input_checker #(
    .SEQ_LEN        (5),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .current_state(current_state),
    .CorrectMemory(mem),
    .buttons      (buttons),
    .input_index  (input_index),
    .input_done   (input_done),
    .input_error  (input_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (input_done) done_cnt <= done_cnt + 1;
      if (input_error) err_cnt <= err_cnt + 1;
      if (input_done && input_error) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    buttons = b;
    wait_cyc(10);
    buttons = 4'b0000;
    wait_cyc(12);
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    done_cnt      = 0;
    err_cnt       = 0;
    both_cnt      = 0;
    reset         = 1'b0;
    buttons       = 4'b0000;
    current_state = 2'b00;
    mem           = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

    // Reset state
    wait_cyc(3);
    check_eq("rst_index", int'(input_index), 0);
    check_eq("rst_done", int'(input_done), 0);
    check_eq("rst_error", int'(input_error), 0);
    check_eq("rst_busy", int'(busy), 0);
    reset = 1'b1;
    wait_cyc(8);

    // Full correct sequence
    snap();
    current_state = 2'b10;
    wait_cyc(2);
    check_eq("a_entry_busy", int'(busy), 1);
    check_eq("a_entry_index", int'(input_index), 0);
    press(4'b0001);
    check_eq("a_index1", int'(input_index), 1);
    press(4'b0010);
    check_eq("a_index2", int'(input_index), 2);
    press(4'b0100);
    check_eq("a_index3", int'(input_index), 3);
    press(4'b1000);
    check_eq("a_index4", int'(input_index), 4);
    check_eq("a_no_done_yet", done_cnt - d0, 0);
    press(4'b0001);
    check_eq("a_index5", int'(input_index), 5);
    check_eq("a_done_pulses", done_cnt - d0, 1);
    check_eq("a_err_pulses", err_cnt - e0, 0);
    check_eq("a_pass_busy", int'(busy), 0);
    current_state = 2'b00;
    wait_cyc(3);
    check_eq("a_idle_index_held", int'(input_index), 5);

    // Wrong first press
    snap();
    current_state = 2'b10;
    wait_cyc(2);
    check_eq("b_entry_index", int'(input_index), 0);
    press(4'b0010);
    check_eq("b_err_pulses", err_cnt - e0, 1);
    check_eq("b_done_pulses", done_cnt - d0, 0);
    check_eq("b_index", int'(input_index), 0);
    check_eq("b_fail_busy", int'(busy), 0);
    current_state = 2'b00;
    wait_cyc(3);

    // Held button counts once
    snap();
    current_state = 2'b10;
    wait_cyc(2);
    buttons = 4'b0001;
    wait_cyc(50);
    check_eq("c_held_index", int'(input_index), 1);
    check_eq("c_held_busy", int'(busy), 1);
    check_eq("c_held_err", err_cnt - e0, 0);
    buttons = 4'b0000;
    wait_cyc(12);
    check_eq("c_release_index", int'(input_index), 1);
    press(4'b0010);
    check_eq("c_repress_index", int'(input_index), 2);

    // Abort after two presses, then re-enter
    current_state = 2'b00;
    wait_cyc(3);
    check_eq("e_abort_busy", int'(busy), 0);
    check_eq("e_abort_index", int'(input_index), 2);
    current_state = 2'b10;
    wait_cyc(2);
    check_eq("e_reentry_index", int'(input_index), 0);
    check_eq("e_reentry_busy", int'(busy), 1);
    check_eq("e_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    // Short glitches are filtered
    snap();
    buttons = 4'b0001;
    wait_cyc(3);
    buttons = 4'b0000;
    wait_cyc(6);
    buttons = 4'b0100;
    wait_cyc(3);
    buttons = 4'b0000;
    wait_cyc(12);
    check_eq("d_glitch_index", int'(input_index), 0);
    check_eq("d_glitch_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check_eq("d_glitch_busy", int'(busy), 1);
    press(4'b0001);
    check_eq("d_after_index", int'(input_index), 1);

    // Two buttons at once is an error
    snap();
    press(4'b0011);
    check_eq("m_err_pulses", err_cnt - e0, 1);
    check_eq("m_index", int'(input_index), 1);
    check_eq("m_busy", int'(busy), 0);

    // Button held while entering INPUT must be released first
    current_state = 2'b00;
    wait_cyc(3);
    snap();
    buttons = 4'b0001;
    wait_cyc(12);
    current_state = 2'b10;
    wait_cyc(2);
    check_eq("h_entry_busy", int'(busy), 1);
    wait_cyc(20);
    check_eq("h_held_index", int'(input_index), 0);
    buttons = 4'b0000;
    wait_cyc(12);
    check_eq("h_release_index", int'(input_index), 0);
    press(4'b0001);
    check_eq("h_press_index", int'(input_index), 1);
    check_eq("h_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    // Timeout behaviour
    current_state = 2'b00;
    wait_cyc(3);
    snap();
    current_state = 2'b10;
`ifdef INPUT_TIMEOUT_EN
    wait_cyc(15);
    check_eq("t_early_busy", int'(busy), 1);
    check_eq("t_early_err", err_cnt - e0, 0);
    wait_cyc(10);
    check_eq("t_err_pulses", err_cnt - e0, 1);
    check_eq("t_fail_busy", int'(busy), 0);
    check_eq("t_index", int'(input_index), 0);
`else
    wait_cyc(1000);
    check_eq("t_still_busy", int'(busy), 1);
    check_eq("t_no_err", err_cnt - e0, 0);
    check_eq("t_index", int'(input_index), 0);
`endif

    // Reset asserted mid-round
    current_state = 2'b00;
    wait_cyc(3);
    current_state = 2'b10;
    wait_cyc(2);
    press(4'b0001);
    check_eq("r_pre_index", int'(input_index), 1);
    snap();
    buttons = 4'b0010;
    wait_cyc(3);
    reset = 1'b0;
    #1;
    check_eq("r_async_index", int'(input_index), 0);
    check_eq("r_async_busy", int'(busy), 0);
    check_eq("r_async_pulse", int'(input_done) + int'(input_error), 0);
    wait_cyc(5);
    buttons = 4'b0000;
    reset = 1'b1;
    wait_cyc(8);
    check_eq("r_after_busy", int'(busy), 1);
    check_eq("r_after_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    press(4'b0001);
    check_eq("r_usable_index", int'(input_index), 1);

    check_eq("never_both_pulses", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
